// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with a valid/ready
// handshake, synchronous flush and a saturating stall counter.
// Define PIPE_SKID_EN to build the 2-entry skid variant. In that variant
// in_ready comes from a flop, so there is no combinational path from
// out_ready to in_ready.
module pipe_stage_reg #(
  parameter int               DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic             w_ti;
  logic             w_to;
  logic             w_stall;
  logic [CNT_W-1:0] r_cnt;

  assign w_ti    = in_valid & in_ready;
  assign w_to    = out_valid & out_ready;
  assign w_stall = out_valid & ~out_ready;

  // Stall counter: clear wins over increment, holds at all-ones, ignores flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           r_cnt <= '0;
    else if (clr_cnt)                  r_cnt <= '0;
    else if (w_stall && r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
  end

  assign stall_cnt = r_cnt;

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rdy;
  logic                w_ld_main;
  logic                w_ld_skid;
  logic                w_main_from_skid;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_skid;

  // Occupancy FSM next-state and load enables; flush overrides everything
  always_comb begin
    w_state_nxt      = r_state;
    w_ld_main        = 1'b0;
    w_ld_skid        = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      EMPTY: if (w_ti) begin
        w_state_nxt = BUSY;
        w_ld_main   = 1'b1;
      end
      BUSY: begin
        if (w_ti && !w_to) begin
          w_state_nxt = FULL;
          w_ld_skid   = 1'b1;
        end else if (w_to && !w_ti) begin
          w_state_nxt = EMPTY;
        end else if (w_ti && w_to) begin
          w_ld_main   = 1'b1;
        end
      end
      FULL: if (w_to) begin
        w_state_nxt      = BUSY;
        w_main_from_skid = 1'b1;
      end
      default: w_state_nxt = EMPTY;
    endcase
    if (flush) begin
      w_state_nxt      = EMPTY;
      w_ld_main        = 1'b0;
      w_ld_skid        = 1'b0;
      w_main_from_skid = 1'b0;
    end
  end

  // State register; ready is precomputed from next state so it is a flop output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_rdy   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= (w_state_nxt != FULL);
    end
  end

  // Payload registers load only on accept or skid promotion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= RST_VAL;
      r_skid <= RST_VAL;
    end else begin
      if (w_ld_main)             r_data <= in_data;
      else if (w_main_from_skid) r_data <= r_skid;
      if (w_ld_skid)             r_skid <= in_data;
    end
  end

  assign in_ready  = r_rdy;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_data;
`else
  logic              r_vld;
  logic [DATA_W-1:0] r_data;

  // Single entry: accept replaces (full throughput), drain clears valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= RST_VAL;
    end else if (flush) begin
      r_vld  <= 1'b0;
    end else if (w_ti) begin
      r_vld  <= 1'b1;
      r_data <= in_data;
    end else if (w_to) begin
      r_vld  <= 1'b0;
    end
  end

  assign in_ready  = ~r_vld | out_ready;
  assign out_valid = r_vld;
  assign out_data  = r_data;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: table vectors, directed corner cases and a
// randomized run against a queue-based occupancy model.
module tb_pipe_stage_reg;

  localparam logic [31:0] RSTV = 32'hDEAD_0000;
  localparam int          CMAX = 15;
`ifdef PIPE_SKID_EN
  localparam int          CAP  = 2;
`else
  localparam int          CAP  = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        clr_cnt = 1'b0;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int failures = 0;

  pipe_stage_reg #(.DATA_W(32), .RST_VAL(RSTV), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .clr_cnt(clr_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of held entries, stall count, registered ready
  logic [31:0] mq[$];
  int          mcnt = 0;
  bit          mrdy = 1'b1;

  function automatic bit exp_ov();
    return mq.size() > 0;
  endfunction

  function automatic bit exp_rdy();
`ifdef PIPE_SKID_EN
    return mrdy;
`else
    return (mq.size() < CAP) || out_ready;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    mcnt = 0;
    mrdy = 1'b1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic drive(input bit iv, input logic [31:0] d, input bit ordy,
                       input bit fl, input bit clr);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    clr_cnt   = clr;
  endtask

  task automatic chk_model();
    chk("ov", {31'b0, out_valid}, {31'b0, exp_ov()});
    chk("rdy", {31'b0, in_ready}, {31'b0, exp_rdy()});
    chk("cnt", {28'b0, stall_cnt}, mcnt);
    if (exp_ov()) chk("data", out_data, mq[0]);
  endtask

  // Advance one clock and apply the handshake rules to the model
  task automatic tick();
    bit ti, to, st;
    ti = in_valid && exp_rdy();
    to = exp_ov() && out_ready;
    st = exp_ov() && !out_ready;
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (to) void'(mq.pop_front());
      if (ti) mq.push_back(in_data);
    end
    if (clr_cnt) mcnt = 0;
    else if (st && mcnt < CMAX) mcnt++;
    mrdy = mq.size() < CAP;
    #1;
  endtask

  task automatic step(input bit iv, input logic [31:0] d, input bit ordy,
                      input bit fl, input bit clr);
    drive(iv, d, ordy, fl, clr);
    #3;
    chk_model();
    tick();
  endtask

  typedef struct {
    bit          iv;
    logic [31:0] d;
    bit          ordy;
    bit          e_ov;
    logic [31:0] e_d;
    bit          e_rdy;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl[9];
  bit   seen55;

  initial begin
    // streaming vectors: 0..7 in, each appears one cycle later
    for (int k = 0; k < 9; k++) begin
      tbl[k].iv    = (k < 8);
      tbl[k].d     = k;
      tbl[k].ordy  = 1'b1;
      tbl[k].e_ov  = (k > 0);
      tbl[k].e_d   = k - 1;
      tbl[k].e_rdy = 1'b1;
      tbl[k].e_cnt = 4'd0;
    end

    // 1. reset values, first transfer
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    #3;
    chk("rst_ov", {31'b0, out_valid}, 32'd0);
    chk("rst_data", out_data, RSTV);
    chk("rst_cnt", {28'b0, stall_cnt}, 32'd0);
    chk("rst_rdy", {31'b0, in_ready}, 32'd1);
    tick();
    drive(1, 32'h1234ABCD, 1, 0, 0); #3; chk_model(); tick();
    drive(0, 0, 1, 0, 0); #3;
    chk("t1_ov", {31'b0, out_valid}, 32'd1);
    chk("t1_data", out_data, 32'h1234ABCD);
    chk_model(); tick();

    // 2. streaming table
    for (int k = 0; k < 9; k++) begin
      drive(tbl[k].iv, tbl[k].d, tbl[k].ordy, 0, 0);
      #3;
      chk("t2_ov", {31'b0, out_valid}, {31'b0, tbl[k].e_ov});
      chk("t2_rdy", {31'b0, in_ready}, {31'b0, tbl[k].e_rdy});
      chk("t2_cnt", {28'b0, stall_cnt}, {28'b0, tbl[k].e_cnt});
      if (tbl[k].e_ov) chk("t2_data", out_data, tbl[k].e_d);
      chk_model();
      tick();
    end

    // 3. hold under stall, count, clear
    step(1, 32'h77, 1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 0); #3;
      chk("t3_hold", out_data, 32'h77);
      chk_model(); tick();
    end
    drive(0, 0, 0, 0, 1); #3;
    chk("t3_cnt5", {28'b0, stall_cnt}, 32'd5);
    chk_model(); tick();
    drive(0, 0, 0, 0, 0); #3;
    chk("t3_clr", {28'b0, stall_cnt}, 32'd0);
    chk_model(); tick();
    step(0, 0, 1, 0, 0);

    // 4. back-pressure with two offered entries
    step(1, 32'hA, 0, 0, 0);
    step(1, 32'hB, 0, 0, 0);
    drive(0, 0, 0, 0, 0); #3;
    chk("t4_rdy", {31'b0, in_ready}, 32'd0);
    chk("t4_head", out_data, 32'hA);
    chk_model(); tick();
    drive(0, 0, 1, 0, 0); #3;
    chk("t4_first", out_data, 32'hA);
    chk_model(); tick();
    drive(0, 0, 1, 0, 0); #3;
`ifdef PIPE_SKID_EN
    chk("t4_second_ov", {31'b0, out_valid}, 32'd1);
    chk("t4_second", out_data, 32'hB);
`else
    chk("t4_drained", {31'b0, out_valid}, 32'd0);
`endif
    chk_model(); tick();
    step(0, 0, 1, 0, 1);

    // 5. flush with a simultaneous incoming entry
    step(1, 32'h66, 0, 0, 0);
    step(1, 32'h55, 0, 1, 0);
    seen55 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 0, 0); #3;
      if (k == 0) begin
        chk("t5_ov", {31'b0, out_valid}, 32'd0);
        chk("t5_rdy", {31'b0, in_ready}, 32'd1);
      end
      if (out_valid && out_data == 32'h55) seen55 = 1'b1;
      chk_model(); tick();
    end
    chk("t5_no55", {31'b0, seen55}, 32'd0);

    // 6. saturation, then asynchronous reset mid-stall
    step(1, 32'h99, 1, 0, 1);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0); #3;
    chk("t6_sat", {28'b0, stall_cnt}, 32'd15);
    chk("t6_ov_pre", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_ov", {31'b0, out_valid}, 32'd0);
    chk("t6_rst_data", out_data, RSTV);
    chk("t6_rst_cnt", {28'b0, stall_cnt}, 32'd0);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      bit ordy;
      if ((k / 200) % 3 == 2) ordy = ($urandom % 8) == 0;
      else                    ordy = ($urandom % 3) != 0;
      step(($urandom % 4) != 0, $urandom, ordy,
           ($urandom % 40) == 0, ($urandom % 60) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
